uart_tx_top: RTL and testbench
==============================

# uart_tx_top

UART transmitter that serialises one 8-bit word per request into a start bit, eight data bits (LSB first), an optional parity bit and one stop bit on a single line. It runs on the same system clock as the receiver (`RX_TOP`) and uses the same `Prescale`, `PAR_EN` and `PAR_TYP` conventions. Its `TX_OUT` can be looped directly into the receiver's `RX_IN`. Each bit is held for `Prescale` clock cycles, so a transmitter and receiver configured identically interoperate.

## Interface
Parameters:
- none; data width fixed at 8, one stop bit.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `ARSTn`  in  1  asynchronous, active-low reset.
- `Prescale`  in  6  clock cycles per bit; 0 means 64.
- `PAR_EN`  in  1  1 = append parity bit.
- `PAR_TYP`  in  1  0 = even parity, 1 = odd parity.
- `P_DATA`  in  8  word to transmit.
- `DATA_VALID`  in  1  transmit request; accepted only when `Busy` = 0.
- `TX_OUT`  out  1  serial line; idle high.
- `Busy`  out  1  high while a frame is in progress.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `TX_OUT` = 1, `Busy` = 0.
  - On a rising edge with `DATA_VALID` = 1, the block latches `P_DATA`, `PAR_EN`, `PAR_TYP` and `Prescale`, then goes to START.
- Latched values are used for the whole frame. Input changes mid-frame have no effect.
- Parity is computed from the latched data at accept:
  - even: XOR of the 8 bits;
  - odd: XNOR of the 8 bits.
- START: drive 0 for one bit time, then go to DATA.
- DATA:
  - Drive data bit `idx`, with a 3-bit index running 0..7 (LSB first).
  - After bit 7, go to PARITY if latched `PAR_EN` = 1, otherwise to STOP.
- PARITY: drive the parity bit for one bit time, then go to STOP.
- STOP: drive 1 for one bit time, then go to IDLE.
- Bit timing:
  - One bit time is set by a 6-bit cycle counter running 0..(`Prescale`-1).
  - The bit advances when the counter equals `Prescale`-1 (6-bit wrap), then the counter clears.
  - `Prescale` = 0 therefore gives 64 cycles per bit.
- `DATA_VALID` while `Busy` = 1 is ignored. There is no queue and no error flag.
- `TX_OUT` and `Busy` are driven directly from flops, so they are glitch-free.

## Timing
- Reset (any time, including mid-frame):
  - `TX_OUT` = 1 and `Busy` = 0 immediately (asynchronous).
  - FSM, counters and latched data are cleared.
  - The next frame after reset release is fully normal.
- Accept edge = the rising edge where `Busy` = 0 and `DATA_VALID` = 1. From the clock after that edge:
  - `TX_OUT` = 0 (start bit) and `Busy` = 1, i.e. one cycle of latency.
- Frame length in cycles:
  - P × 10 without parity, P × 11 with parity, where P = `Prescale` (64 if 0).
  - `Busy` is high for exactly that many cycles.
- `Busy` falls on the same edge on which `TX_OUT` leaves the stop bit; the line is already 1 and stays 1.
- The earliest next accept is the edge where `Busy` is first seen 0. The minimum inter-frame gap is therefore 1 idle cycle at line level 1.
- A `DATA_VALID` held high continuously produces back-to-back frames, each separated by that 1 idle cycle.

## Test plan
- Reset: hold `ARSTn` = 0 with `DATA_VALID` = 1 → `TX_OUT` = 1 and `Busy` = 0 throughout; no frame starts until after release.
- No parity:
  - Setup: `Prescale` = 8, `PAR_EN` = 0, `P_DATA` = 8'hDB, one-cycle `DATA_VALID`.
  - Required: `TX_OUT` = 0,1,1,0,1,1,0,1,1,1, each held 8 cycles; `Busy` high for exactly 80 cycles.
  - Loopback into `RX_TOP` yields `P_DATA` = 8'hDB, `DATA_VLD` pulse, `PAR_ERR` = `STP_ERR` = 0.
- Parity:
  - Setup: `Prescale` = 8, `PAR_EN` = 1, `P_DATA` = 8'h07.
  - `PAR_TYP` = 0 → parity bit 1; `PAR_TYP` = 1 → parity bit 0.
  - 11 bits per frame; `Busy` high for 88 cycles.
  - Loopback gives no `PAR_ERR`.
- Busy-ignore and latching:
  - Pulse `DATA_VALID` with `P_DATA` = 8'h55 mid-frame, and change `P_DATA`, `PAR_EN` and `Prescale` mid-frame.
  - Required: the current frame is unchanged and no extra frame is sent.
  - Holding `DATA_VALID` high gives consecutive frames with exactly 1 idle-high cycle between them.
- Reset mid-frame:
  - Assert `ARSTn` = 0 during data bit 3.
  - Required: `TX_OUT` = 1 and `Busy` = 0 immediately; after release, a new frame of 8'hA5 is transmitted correctly.
- Prescale extremes:
  - `Prescale` = 16 → 16 cycles per bit.
  - `Prescale` = 0 → 64 cycles per bit; `Busy` high for 640 cycles without parity.
  - `Prescale` = 1 → 1 cycle per bit; `Busy` high for 10 cycles.

Source files
------------

// File: rtl/uart_tx_top.sv
// uart_tx_top: 8-bit UART transmitter, LSB first, optional parity, one stop bit, Prescale clocks per bit
module uart_tx_top (
    input  logic       clk,
    input  logic       ARSTn,
    input  logic [5:0] Prescale,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    input  logic [7:0] P_DATA,
    input  logic       DATA_VALID,
    output logic       TX_OUT,
    output logic       Busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t     r_state, w_next;
    logic [5:0] r_cnt, r_presc;
    logic [2:0] r_idx, w_idx_inc;
    logic [7:0] r_data;
    logic       r_par_en, r_par, r_tx, r_busy;
    logic       w_done, w_accept, w_tx_next;
    // Prescale of 0 wraps to 63 here, which yields 64 cycles per bit
    assign w_done    = r_cnt == r_presc - 6'd1;
    assign w_accept  = r_state == IDLE && DATA_VALID;
    assign w_idx_inc = r_idx + 3'd1;
    assign TX_OUT    = r_tx;
    assign Busy      = r_busy;
    // Next state and the line level that the next state will drive
    always_comb begin
        w_next    = r_state;
        w_tx_next = r_tx;
        case (r_state)
            IDLE: if (DATA_VALID) begin
                w_next    = START;
                w_tx_next = 1'b0;
            end
            START: if (w_done) begin
                w_next    = DATA;
                w_tx_next = r_data[0];
            end
            DATA: if (w_done) begin
                if (r_idx == 3'd7) begin
                    w_next    = r_par_en ? PARITY : STOP;
                    w_tx_next = r_par_en ? r_par : 1'b1;
                end else begin
                    w_tx_next = r_data[w_idx_inc];
                end
            end
            PARITY: if (w_done) begin
                w_next    = STOP;
                w_tx_next = 1'b1;
            end
            STOP: if (w_done) begin
                w_next    = IDLE;
                w_tx_next = 1'b1;
            end
            default: begin
                w_next    = IDLE;
                w_tx_next = 1'b1;
            end
        endcase
    end
    // State and registered outputs, so the line and Busy never glitch
    always_ff @(posedge clk or negedge ARSTn) begin
        if (!ARSTn) begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_tx    <= w_tx_next;
            r_busy  <= w_next != IDLE;
        end
    end
    // Bit-time counter and data bit index
    always_ff @(posedge clk or negedge ARSTn) begin
        if (!ARSTn) begin
            r_cnt <= 6'd0;
            r_idx <= 3'd0;
        end else begin
            r_cnt <= (r_state == IDLE || w_done) ? 6'd0 : r_cnt + 6'd1;
            r_idx <= r_state != DATA ? 3'd0 : w_done ? w_idx_inc : r_idx;
        end
    end
    // Frame settings captured at accept so mid-frame input changes are ignored
    always_ff @(posedge clk or negedge ARSTn) begin
        if (!ARSTn) begin
            r_data   <= 8'd0;
            r_par_en <= 1'b0;
            r_par    <= 1'b0;
            r_presc  <= 6'd0;
        end else if (w_accept) begin
            r_data   <= P_DATA;
            r_par_en <= PAR_EN;
            r_par    <= ^P_DATA ^ PAR_TYP;
            r_presc  <= Prescale;
        end
    end
endmodule

// File: tb/tb_uart_tx_top.sv
// tb_uart_tx_top: directed checks of frame shape, timing, latching and reset of uart_tx_top
module tb_uart_tx_top;
    logic       clk;
    logic       ARSTn;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       TX_OUT;
    logic       Busy;
    int         checks;
    int         fails;

    uart_tx_top dut (
        .clk        (clk),
        .ARSTn      (ARSTn),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Present a request at a negedge; accept happens on the following posedge
    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] p, input bit hold);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Prescale   = p;
        DATA_VALID = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) DATA_VALID = 1'b0;
    endtask

    // Called just after the accept edge; checks every cycle of the frame and the idle cycle after it
    task automatic check_frame(input string tag, input logic [7:0] d, input bit pe, input bit pbit, input int p, input bit disturb);
        logic exp_bits [11];
        int   nbits;
        int   busy_cnt;
        int   match;
        int   cyc;
        nbits       = pe ? 11 : 10;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[1 + i] = d[i];
        exp_bits[9]  = pe ? pbit : 1'b1;
        exp_bits[10] = 1'b1;
        busy_cnt = 0;
        cyc      = 0;
        for (int b = 0; b < nbits; b++) begin
            match = 0;
            for (int c = 0; c < p; c++) begin
                @(negedge clk);
                if (TX_OUT === exp_bits[b]) match++;
                if (Busy === 1'b1) busy_cnt++;
                if (disturb && cyc == 20) begin
                    P_DATA     = 8'h55;
                    PAR_EN     = 1'b1;
                    Prescale   = 6'd3;
                    DATA_VALID = 1'b1;
                end
                if (disturb && cyc == 21) DATA_VALID = 1'b0;
                cyc++;
            end
            chk($sformatf("%s bit%0d", tag, b), match, p);
        end
        chk($sformatf("%s busy_len", tag), busy_cnt, nbits * p);
        @(negedge clk);
        chk($sformatf("%s gap_tx", tag), TX_OUT, 1);
        chk($sformatf("%s gap_busy", tag), Busy, 0);
    endtask

    initial begin
        int ok;
        checks     = 0;
        fails      = 0;
        ARSTn      = 1'b0;
        DATA_VALID = 1'b1;
        P_DATA     = 8'hDB;
        Prescale   = 6'd8;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        ok = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (TX_OUT === 1'b1 && Busy === 1'b0) ok++;
        end
        chk("reset_hold_idle", ok, 5);
        ARSTn      = 1'b1;
        DATA_VALID = 1'b0;
        @(negedge clk);
        chk("post_reset_tx", TX_OUT, 1);
        chk("post_reset_busy", Busy, 0);

        send(8'hDB, 1'b0, 1'b0, 6'd8, 1'b0);
        check_frame("db_nopar", 8'hDB, 1'b0, 1'b0, 8, 1'b0);

        send(8'h07, 1'b1, 1'b0, 6'd8, 1'b0);
        check_frame("07_even", 8'h07, 1'b1, 1'b1, 8, 1'b0);
        send(8'h07, 1'b1, 1'b1, 6'd8, 1'b0);
        check_frame("07_odd", 8'h07, 1'b1, 1'b0, 8, 1'b0);

        send(8'h3C, 1'b0, 1'b0, 6'd8, 1'b0);
        check_frame("latch", 8'h3C, 1'b0, 1'b0, 8, 1'b1);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (TX_OUT === 1'b1 && Busy === 1'b0) ok++;
        end
        chk("no_extra_frame", ok, 20);

        send(8'hC6, 1'b0, 1'b0, 6'd4, 1'b1);
        check_frame("b2b_a", 8'hC6, 1'b0, 1'b0, 4, 1'b0);
        P_DATA = 8'h39;
        @(posedge clk);
        #1;
        DATA_VALID = 1'b0;
        check_frame("b2b_b", 8'h39, 1'b0, 1'b0, 4, 1'b0);

        send(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0);
        for (int i = 0; i < 35; i++) @(negedge clk);
        chk("pre_rst_tx", TX_OUT, 0);
        #2;
        ARSTn = 1'b0;
        #1;
        chk("async_rst_tx", TX_OUT, 1);
        chk("async_rst_busy", Busy, 0);
        @(negedge clk);
        ARSTn = 1'b1;
        @(negedge clk);
        chk("rst_release_busy", Busy, 0);
        send(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0);
        check_frame("a5_after_rst", 8'hA5, 1'b0, 1'b0, 8, 1'b0);

        send(8'h3C, 1'b0, 1'b0, 6'd16, 1'b0);
        check_frame("p16", 8'h3C, 1'b0, 1'b0, 16, 1'b0);
        send(8'h81, 1'b0, 1'b0, 6'd0, 1'b0);
        check_frame("p0", 8'h81, 1'b0, 1'b0, 64, 1'b0);
        send(8'hDB, 1'b0, 1'b0, 6'd1, 1'b0);
        check_frame("p1", 8'hDB, 1'b0, 1'b0, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
